// File: rtl/prbs64_checker.sv
// prbs64_checker
//   Receive-side checker for the 64-bit XNOR LFSR pattern generator.
//   It loads a local 64-bit reference from the incoming bits (FILL), then
//   runs that reference on its own predictions (CHECK) and compares every
//   received bit against it. Bit errors are counted. When LOSS_THRESH errors
//   land inside one WINDOW-bit window, lock is dropped and the reference is
//   refilled.
//
// Ports
//   clk        : clock, rising edge
//   reset      : synchronous, active-high
//   in_valid   : qualifies in_bit
//   in_bit     : received pattern bit, oldest first
//   clear_cnt  : synchronous clear of err_count / bit_count
//   locked     : high while in CHECK
//   err_pulse  : one-cycle pulse per mismatched bit
//   lock_lost  : one-cycle pulse when the error threshold forces re-acquisition
//   err_count  : saturating mismatch count while locked
//   bit_count  : saturating count of checked bits while locked
module prbs64_checker #(
  parameter int unsigned CNT_W       = 32,
  parameter int unsigned WINDOW      = 256,
  parameter int unsigned LOSS_THRESH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             clear_cnt,
  output logic             locked,
  output logic             err_pulse,
  output logic             lock_lost,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] bit_count
);

  localparam int unsigned WIN_W  = (WINDOW > 2) ? $clog2(WINDOW) : 1;
  localparam int unsigned WERR_W = $clog2(LOSS_THRESH + 1);

  typedef enum logic {
    S_FILL,
    S_CHECK
  } state_t;

  state_t             state_q, state_d;
  logic [63:0]        h_q, h_d;
  logic [5:0]         fill_cnt_q, fill_cnt_d;
  logic [WIN_W-1:0]   win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]  win_err_q, win_err_d;
  logic               err_pulse_q, err_pulse_d;
  logic               lock_lost_q, lock_lost_d;
  logic [CNT_W-1:0]   err_count_q, err_count_d;
  logic [CNT_W-1:0]   bit_count_q, bit_count_d;

  logic               exp_bit;
  logic               err;
  logic [WERR_W:0]    win_err_sum;

  // Reference prediction from the current history (same taps as the generator).
  assign exp_bit     = ~(h_q[63] ^ h_q[62] ^ h_q[60] ^ h_q[59]);
  assign err         = in_bit ^ exp_bit;
  assign win_err_sum = {1'b0, win_err_q} + (WERR_W + 1)'(err);

  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    fill_cnt_d  = fill_cnt_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    err_pulse_d = 1'b0;
    lock_lost_d = 1'b0;
    err_count_d = err_count_q;
    bit_count_d = bit_count_q;

    if (in_valid) begin
      unique case (state_q)
        S_FILL: begin
          h_d = {h_q[62:0], in_bit};
          if (fill_cnt_q == 6'd63) begin
            fill_cnt_d = '0;
            // An all-ones history is the XNOR lockup state; keep filling.
            if (h_d != '1) begin
              state_d   = S_CHECK;
              win_cnt_d = '0;
              win_err_d = '0;
            end
          end else begin
            fill_cnt_d = fill_cnt_q + 6'd1;
          end
        end

        S_CHECK: begin
          // Flywheel: the reference advances on its own prediction, so a
          // single corrupted bit produces exactly one error.
          h_d         = {h_q[62:0], exp_bit};
          err_pulse_d = err;
          if (bit_count_q != '1) bit_count_d = bit_count_q + CNT_W'(1);
          if (err && (err_count_q != '1)) err_count_d = err_count_q + CNT_W'(1);

          if (win_err_sum >= (WERR_W + 1)'(LOSS_THRESH)) begin
            state_d     = S_FILL;
            lock_lost_d = 1'b1;
            h_d         = '0;
            fill_cnt_d  = '0;
            win_cnt_d   = '0;
            win_err_d   = '0;
          end else begin
            win_cnt_d = win_cnt_q + WIN_W'(1);
            if (win_cnt_q == WIN_W'(WINDOW - 1)) win_err_d = '0;
            else                                 win_err_d = win_err_sum[WERR_W-1:0];
          end
        end

        default: state_d = S_FILL;
      endcase
    end

    if (clear_cnt) begin
      err_count_d = '0;
      bit_count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FILL;
      h_q         <= '0;
      fill_cnt_q  <= '0;
      win_cnt_q   <= '0;
      win_err_q   <= '0;
      err_pulse_q <= 1'b0;
      lock_lost_q <= 1'b0;
      err_count_q <= '0;
      bit_count_q <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      fill_cnt_q  <= fill_cnt_d;
      win_cnt_q   <= win_cnt_d;
      win_err_q   <= win_err_d;
      err_pulse_q <= err_pulse_d;
      lock_lost_q <= lock_lost_d;
      err_count_q <= err_count_d;
      bit_count_q <= bit_count_d;
    end
  end

  assign locked    = (state_q == S_CHECK);
  assign err_pulse = err_pulse_q;
  assign lock_lost = lock_lost_q;
  assign err_count = err_count_q;
  assign bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs64_checker.sv
// tb_prbs64_checker
//   Scoreboard bench for prbs64_checker. The driver pushes the expected
//   {locked, err_pulse, lock_lost} for every valid bit; a monitor pops and
//   compares one clock later. Counter values are checked at phase ends.
module tb_prbs64_checker;

  localparam int unsigned CNT_W = 32;
  localparam logic [63:0] SEED  = 64'h0123_4567_89AB_CDEF;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_bit = 1'b0;
  logic             clear_cnt = 1'b0;
  logic             locked;
  logic             err_pulse;
  logic             lock_lost;
  logic [CNT_W-1:0] err_count;
  logic [CNT_W-1:0] bit_count;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  logic [2:0]  exp_q[$];
  logic [63:0] g;

  prbs64_checker #(
    .CNT_W      (CNT_W),
    .WINDOW     (256),
    .LOSS_THRESH(8)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_bit   (in_bit),
    .clear_cnt(clear_cnt),
    .locked   (locked),
    .err_pulse(err_pulse),
    .lock_lost(lock_lost),
    .err_count(err_count),
    .bit_count(bit_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Generator model: emit feedback bit and shift it in.
  function automatic logic gen_step(inout logic [63:0] s);
    logic x;
    x = ~(s[63] ^ s[62] ^ s[60] ^ s[59]);
    s = {s[62:0], x};
    return x;
  endfunction

  task automatic send(input logic b, input logic clr,
                      input logic e_lock, input logic e_err, input logic e_loss);
    @(negedge clk);
    in_valid  = 1'b1;
    in_bit    = b;
    clear_cnt = clr;
    exp_q.push_back({e_lock, e_err, e_loss});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(negedge clk);
      in_valid  = 1'b0;
      clear_cnt = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset     = 1'b1;
    in_valid  = 1'b0;
    clear_cnt = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_locked", 64'(locked), 64'd0);
    chk("rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("rst_lock_lost", 64'(lock_lost), 64'd0);
    chk("rst_err_count", 64'(err_count), 64'd0);
    chk("rst_bit_count", 64'(bit_count), 64'd0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Monitor: outputs after each edge reflect the inputs sampled at that edge.
  always begin
    logic [2:0] e;
    @(posedge clk);
    #1;
    if (!reset) begin
      if (in_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL scoreboard_empty: got empty queue expected an entry at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          chk("mon_locked", 64'(locked), 64'(e[2]));
          chk("mon_err_pulse", 64'(err_pulse), 64'(e[1]));
          chk("mon_lock_lost", 64'(lock_lost), 64'(e[0]));
        end
      end else begin
        chk("idle_err_pulse", 64'(err_pulse), 64'd0);
        chk("idle_lock_lost", 64'(lock_lost), 64'd0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic x;

    // 1: clean stream, lock after bit 64, 136 bits checked.
    do_reset();
    g = SEED;
    for (int unsigned i = 1; i <= 200; i++) begin
      x = gen_step(g);
      send(x, 1'b0, i >= 64, 1'b0, 1'b0);
    end
    idle(1);
    chk("p1_err_count", 64'(err_count), 64'd0);
    chk("p1_bit_count", 64'(bit_count), 64'd136);

    // 2: single flipped bit 100 -> exactly one error.
    do_reset();
    g = SEED;
    for (int unsigned i = 1; i <= 200; i++) begin
      x = gen_step(g);
      send(x ^ (i == 100), 1'b0, i >= 64, i == 100, 1'b0);
    end
    idle(1);
    chk("p2_err_count", 64'(err_count), 64'd1);
    chk("p2_bit_count", 64'(bit_count), 64'd136);

    // 3: eight errors in one window -> loss at bit 140, relock at bit 204.
    do_reset();
    g = SEED;
    for (int unsigned i = 1; i <= 230; i++) begin
      logic bad;
      x   = gen_step(g);
      bad = (i >= 70) && (i <= 140) && (i % 10 == 0);
      send(x ^ bad, 1'b0, (i >= 64 && i < 140) || (i >= 204), bad, i == 140);
      if (i == 140) chk("p3_err_at_loss", 64'(err_count), 64'd8);
      if (i == 204) begin
        chk("p3_err_held", 64'(err_count), 64'd8);
        chk("p3_bits_held", 64'(bit_count), 64'd76);
      end
    end
    idle(1);
    chk("p3_err_count", 64'(err_count), 64'd8);
    chk("p3_bit_count", 64'(bit_count), 64'd102);

    // 4: 64 ones is the lockup pattern; lock only after a real fill.
    do_reset();
    for (int unsigned i = 1; i <= 64; i++) send(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    g = SEED;
    for (int unsigned i = 1; i <= 80; i++) begin
      x = gen_step(g);
      send(x, 1'b0, i >= 64, 1'b0, 1'b0);
    end
    idle(1);
    chk("p4_err_count", 64'(err_count), 64'd0);
    chk("p4_bit_count", 64'(bit_count), 64'd16);

    // 5: test-1 stream with sparse valid and random gaps.
    do_reset();
    g = SEED;
    for (int unsigned i = 1; i <= 200; i++) begin
      x = gen_step(g);
      send(x, 1'b0, i >= 64, 1'b0, 1'b0);
      idle(2 + $urandom_range(0, 3));
    end
    chk("p5_err_count", 64'(err_count), 64'd0);
    chk("p5_bit_count", 64'(bit_count), 64'd136);

    // 6: clear_cnt wins over a same-cycle error; then reset mid-CHECK.
    do_reset();
    g = SEED;
    for (int unsigned i = 1; i <= 82; i++) begin
      x = gen_step(g);
      send(x ^ (i == 81), i == 81, i >= 64, i == 81, 1'b0);
      if (i == 81) begin
        chk("p6_clr_err", 64'(err_count), 64'd0);
        chk("p6_clr_bits", 64'(bit_count), 64'd0);
      end
    end
    chk("p6_after_clr_bits", 64'(bit_count), 64'd1);
    chk("p6_after_clr_err", 64'(err_count), 64'd0);
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b1;
    in_bit   = gen_step(g);
    @(posedge clk);
    #1;
    chk("p6_rst_locked", 64'(locked), 64'd0);
    chk("p6_rst_err_pulse", 64'(err_pulse), 64'd0);
    chk("p6_rst_lock_lost", 64'(lock_lost), 64'd0);
    chk("p6_rst_err_count", 64'(err_count), 64'd0);
    chk("p6_rst_bit_count", 64'(bit_count), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b0;
    for (int unsigned i = 1; i <= 70; i++) begin
      x = gen_step(g);
      send(x, 1'b0, i >= 64, 1'b0, 1'b0);
    end
    idle(1);
    chk("p6_relock_bits", 64'(bit_count), 64'd6);
    chk("p6_relock_err", 64'(err_count), 64'd0);

    idle(2);
    chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
